// File: rtl/morse_pkg.sv
// morse_pkg: shared letter codes, receiver states and line-timing constants for the Morse link
package morse_pkg;
    typedef enum logic [2:0] {A, B, C, D, E, F, G, H} letter_t;
    typedef enum logic [1:0] {IDLE, MARK, SPACE, FLUSH} rx_state_t;
    localparam logic [2:0] DOT_TICKS   = 3'd1;
    localparam logic [2:0] DASH_TICKS  = 3'd3;
    localparam logic [1:0] GAP_TICKS   = 2'd3;
    localparam logic [2:0] MAX_SYMBOLS = 3'd4;
endpackage

// File: rtl/morse_receiver_if.sv
// morse_receiver_if: keyed-line inputs and decoded-letter outputs of the Morse receiver
interface morse_receiver_if;
    import morse_pkg::*;
    logic    tick;
    logic    bit_in;
    letter_t letter;
    logic    letter_valid;
    logic    error;
    logic    busy;
    modport master (output tick, bit_in, input letter, letter_valid, error, busy);
    modport slave  (input tick, bit_in, output letter, letter_valid, error, busy);
endinterface

// File: rtl/morse_symbol_decode.sv
// morse_symbol_decode: maps a held dot/dash pattern and its length onto a letter code
module morse_symbol_decode
    import morse_pkg::*;
(
    input  logic [2:0] sym_cnt,
    input  logic [3:0] sym_bits,
    output letter_t    letter,
    output logic       ok
);
    // Unused high bits of the store are always zero, so the full 7-bit key is matched
    always_comb begin
        letter = A;
        ok     = 1'b1;
        case ({sym_cnt, sym_bits})
            {3'd2, 4'b0001}: letter = A;
            {3'd4, 4'b1000}: letter = B;
            {3'd4, 4'b1010}: letter = C;
            {3'd3, 4'b0100}: letter = D;
            {3'd1, 4'b0000}: letter = E;
            {3'd4, 4'b0010}: letter = F;
            {3'd3, 4'b0110}: letter = G;
            {3'd4, 4'b0000}: letter = H;
            default:         ok = 1'b0;
        endcase
    end
endmodule

// File: rtl/morse_receiver.sv
// morse_receiver: measures mark/space run lengths on tick strobes and decodes letters A-H
module morse_receiver
    import morse_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    morse_receiver_if.slave  rx
);
    rx_state_t  state;
    logic [2:0] mark_cnt;
    logic [2:0] sym_cnt;
    logic [1:0] space_cnt;
    logic [3:0] sym_bits;
    letter_t    dec_letter;
    logic       dec_ok;

    morse_symbol_decode u_decode (
        .sym_cnt  (sym_cnt),
        .sym_bits (sym_bits),
        .letter   (dec_letter),
        .ok       (dec_ok)
    );

    // Receiver FSM; entering FLUSH on a space tick counts that tick toward the 3-tick flush gap
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            mark_cnt        <= '0;
            space_cnt       <= '0;
            sym_bits        <= '0;
            sym_cnt         <= '0;
            rx.letter       <= A;
            rx.letter_valid <= 1'b0;
            rx.error        <= 1'b0;
            rx.busy         <= 1'b0;
        end else begin
            rx.letter_valid <= 1'b0;
            rx.error        <= 1'b0;
            if (rx.tick) begin
                case (state)
                    IDLE: if (rx.bit_in) begin
                        state    <= MARK;
                        rx.busy  <= 1'b1;
                        mark_cnt <= 3'd1;
                        sym_bits <= '0;
                        sym_cnt  <= '0;
                    end
                    MARK: if (rx.bit_in) begin
                        mark_cnt <= mark_cnt + 3'd1;
                        if (mark_cnt == DASH_TICKS) begin
                            rx.error  <= 1'b1;
                            state     <= FLUSH;
                            space_cnt <= 2'd0;
                        end
                    end else if ((mark_cnt == DOT_TICKS || mark_cnt == DASH_TICKS) && sym_cnt != MAX_SYMBOLS) begin
                        sym_bits  <= {sym_bits[2:0], mark_cnt == DASH_TICKS};
                        sym_cnt   <= sym_cnt + 3'd1;
                        state     <= SPACE;
                        space_cnt <= 2'd1;
                    end else begin
                        rx.error  <= 1'b1;
                        state     <= FLUSH;
                        space_cnt <= 2'd1;
                    end
                    SPACE: if (!rx.bit_in) begin
                        space_cnt <= space_cnt + 2'd1;
                        if (space_cnt == GAP_TICKS - 2'd1) begin
                            state           <= IDLE;
                            rx.busy         <= 1'b0;
                            rx.letter       <= dec_ok ? dec_letter : rx.letter;
                            rx.letter_valid <= dec_ok;
                            rx.error        <= !dec_ok;
                        end
                    end else if (space_cnt == 2'd1) begin
                        state    <= MARK;
                        mark_cnt <= 3'd1;
                    end else begin
                        rx.error  <= 1'b1;
                        state     <= FLUSH;
                        space_cnt <= 2'd0;
                    end
                    FLUSH: if (rx.bit_in) begin
                        space_cnt <= 2'd0;
                    end else begin
                        space_cnt <= space_cnt + 2'd1;
                        if (space_cnt == GAP_TICKS - 2'd1) begin
                            state   <= IDLE;
                            rx.busy <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/morse_receiver.md
# morse_receiver

Serial Morse decoder for the lab 5 Morse datapath. It samples a keyed line once per bit-period `tick`, measures mark and space run lengths, and assembles dot/dash symbols. At end of letter it decodes them back to the 3-bit letter code A–H, the same code the Morse transmitter takes as `Letter`. It pairs with the transmitter as the other end of the link: the transmitter's `DotDashOut` drives `bit_in`, and the transmitter's `NewBitOut` drives `tick`.

## Interface
- Parameters: none. Timing and symbol constants live in `morse_pkg`.
- `clock`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state and outputs.
- `tick`  in  1  one-cycle bit-period strobe; `bit_in` is sampled only on cycles with `tick`=1.
- `bit_in`  in  1  keyed line; 1 = mark (key down), 0 = space.
- `letter`  out  3  last decoded letter: A=000, B=001, C=010, D=011, E=100, F=101, G=110, H=111.
- `letter_valid`  out  1  one-cycle pulse when `letter` is updated.
- `error`  out  1  one-cycle pulse on a malformed symbol or letter.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Line coding, in ticks:
  - dot = mark of 1
  - dash = mark of 3
  - intra-letter gap = space of 1
  - end of letter = space of 3
- Symbol store:
  - `sym_bits[3:0]`: dot=0, dash=1, new symbol shifted in at the LSB.
  - `sym_cnt[2:0]`: number of symbols held, 0–4.
- Decode key (count, bits):
  - A (2, 01), B (4, 1000), C (4, 1010), D (3, 100)
  - E (1, 0), F (4, 0010), G (3, 110), H (4, 0000)
  - Any other combination → error.
- FSM states: IDLE, MARK, SPACE, FLUSH. Each transition below happens only on a `tick` cycle.
  - IDLE:
    - `bit_in`=0 → stay.
    - `bit_in`=1 → MARK, `mark_cnt`=1, symbol store cleared.
  - MARK:
    - `bit_in`=1 → `mark_cnt`+1. If `mark_cnt` reaches 4 → error, go to FLUSH.
    - `bit_in`=0 → classify the mark: 1 = dot, 3 = dash, 2 = error (go to FLUSH).
    - On a valid mark: if `sym_cnt`=4 → error, go to FLUSH. Otherwise push the symbol, go to SPACE with `space_cnt`=1.
  - SPACE:
    - `bit_in`=0 → `space_cnt`+1. At 3 → decode; emit `letter_valid` or `error`; go to IDLE.
    - `bit_in`=1 with `space_cnt`=1 → MARK, `mark_cnt`=1.
    - `bit_in`=1 with `space_cnt`=2 → error, go to FLUSH.
  - FLUSH:
    - `bit_in`=1 → `space_cnt`=0.
    - `bit_in`=0 → `space_cnt`+1. At 3 → IDLE. No output in this state.
- `letter` holds its value until the next valid decode. An error does not change `letter`.
- Reset values: `letter`=000, `letter_valid`=0, `error`=0, `busy`=0, state IDLE, all counters and the symbol store 0.

## Timing
- `letter`, `letter_valid`, `error`, and `busy` are all registered.
- `letter_valid` and `error` assert in the cycle immediately after the deciding tick, for exactly one cycle. They are never high together.
- Cycles with `tick`=0 hold all state; `bit_in` is ignored on those cycles.
- `tick` may be high every cycle. Back-to-back letters need no extra idle beyond the 3-tick letter gap.
- `reset` takes priority over `tick`. Reset mid-letter discards partial symbols and raises no `error`.
- A continuous-space line stays in IDLE indefinitely with no output.
- A stuck-high line errors once, when `mark_cnt` reaches 4. It then stays in FLUSH until 3 space ticks are seen.

## Structure
- `morse_pkg` holds:
  - `letter_t` enum (A–H = 0–7)
  - `rx_state_t` enum (IDLE, MARK, SPACE, FLUSH)
  - `DOT_TICKS`=1, `DASH_TICKS`=3, `GAP_TICKS`=3, `MAX_SYMBOLS`=4
- Sub-module `morse_symbol_decode`: combinational map of (`sym_cnt`, `sym_bits`) → {letter, ok}.
- The top level holds the FSM, the counters, the symbol shift register, and the output registers.

## Test plan
- Reset; `tick` every 4th cycle; `bit_in` stream 10111 then 000 → one `letter_valid` pulse with `letter`=000 (A); `error` stays 0.
- `tick` every cycle; stream 111010111010 then 00 → `letter`=010 (C). Then immediately 1000 → `letter`=100 (E).
- Stream 110 then 00 → `error` pulse one cycle after the falling tick; no `letter_valid`. Then 1000 → `letter`=100.
- Stream 1010101010 (five dots) → `error` pulse on the 5th dot's falling tick. After 000 flush, 10101010 00 → `letter`=111 (H).
- Stream 10 0 1 (space of 2 between marks) → `error`. Stream 11 11 (4-tick mark) → `error` on the 4th mark tick; `busy` stays 1 until 3 space ticks are seen.
- Stream 1110, assert `reset` for one cycle, then 1000 → no `error`; single `letter_valid` with `letter`=100.
